// File: rtl/seq_mult_writer.sv
// Sequential 8x8 multiplier that writes its 16-bit product into the product register.
// Define MULT_SIGNED_EN for two's-complement operands (radix-2 Booth); default is unsigned shift-add.
module seq_mult_writer #(
    parameter int unsigned OPW    = 8,
    parameter int unsigned ITER_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OPW-1:0]     opA,
    input  logic [OPW-1:0]     opB,
    output logic               busy,
    output logic               done,
    output logic               regWrite,
    output logic               decOut1b,
    output logic [2*OPW-1:0]   writeData
);

    typedef enum logic [1:0] {StIdle, StRun, StWrite} stateT;

    stateT             state;
    logic [OPW-1:0]    mcand;
    logic [OPW-1:0]    mplier;
    logic [2*OPW-1:0]  acc;
    logic [ITER_W-1:0] iter;
    logic [OPW:0]      hiSum;
    logic [2*OPW-1:0]  accNext;
`ifdef MULT_SIGNED_EN
    logic              prevBit;
`endif

    // Upper half is widened by one bit so the carry (or Booth sign) survives the shift.
    always_comb begin
`ifdef MULT_SIGNED_EN
        hiSum = {acc[2*OPW-1], acc[2*OPW-1:OPW]};
        case ({mplier[0], prevBit})
            2'b01:   hiSum = hiSum + {mcand[OPW-1], mcand};
            2'b10:   hiSum = hiSum - {mcand[OPW-1], mcand};
            default: hiSum = {acc[2*OPW-1], acc[2*OPW-1:OPW]};
        endcase
`else
        hiSum = {1'b0, acc[2*OPW-1:OPW]};
        if (mplier[0]) begin
            hiSum = hiSum + {1'b0, mcand};
        end
`endif
        accNext = {hiSum, acc[OPW-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            regWrite  <= 1'b0;
            decOut1b  <= 1'b0;
            writeData <= '0;
`ifdef MULT_SIGNED_EN
            prevBit   <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            regWrite <= 1'b0;
            decOut1b <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        mcand <= opA;
                        mplier <= opB;
                        acc   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= StRun;
`ifdef MULT_SIGNED_EN
                        prevBit <= 1'b0;
`endif
                    end
                end
                StRun: begin
                    acc    <= accNext;
                    mplier <= mplier >> 1;
                    iter   <= iter + 1'b1;
`ifdef MULT_SIGNED_EN
                    prevBit <= mplier[0];
`endif
                    if (iter == ITER_W'(OPW - 1)) begin
                        state     <= StWrite;
                        writeData <= accNext;
                        regWrite  <= 1'b1;
                        decOut1b  <= 1'b1;
                    end
                end
                StWrite: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_writer.sv
// Scoreboard bench for seq_mult_writer: stimulus queues expected products, a monitor checks writes.
module tb_seq_mult_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  opA = '0;
    logic [7:0]  opB = '0;
    logic        busy, done, regWrite, decOut1b;
    logic [15:0] writeData;

    seq_mult_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .done      (done),
        .regWrite  (regWrite),
        .decOut1b  (decOut1b),
        .writeData (writeData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] expData[$];
    int          expCyc[$];
    int          nTests = 0;
    int          nFail = 0;
    logic        prevRw = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: strobe consistency and scoreboard pops on every write.
    initial begin
        logic [15:0] d;
        int c;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevRw = 1'b0;
            end else begin
                check("decOut1bEqRegWrite", {31'b0, decOut1b}, {31'b0, regWrite});
                check("doneAfterWrite", {31'b0, done}, {31'b0, prevRw});
                if (regWrite) begin
                    if (expData.size() == 0) begin
                        check("spuriousWrite", {31'b0, regWrite}, 32'd0);
                    end else begin
                        d = expData.pop_front();
                        c = expCyc.pop_front();
                        check("product", {16'b0, writeData}, {16'b0, d});
                        check("strobeLatency", cyc - c, 32'd8);
                    end
                end
                prevRw = regWrite;
            end
        end
    end

    task automatic checkAllZero(input string tag);
        check({tag, "Busy"}, {31'b0, busy}, 32'd0);
        check({tag, "Done"}, {31'b0, done}, 32'd0);
        check({tag, "RegWrite"}, {31'b0, regWrite}, 32'd0);
        check({tag, "DecOut1b"}, {31'b0, decOut1b}, 32'd0);
        check({tag, "WriteData"}, {16'b0, writeData}, 32'd0);
    endtask

    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e,
                         input bit pulseMid);
        @(negedge clk);
        opA = a;
        opB = b;
        start = 1'b1;
        expData.push_back(e);
        expCyc.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        opA = ~a;
        opB = ~b;
        check("busyAfterAccept", {31'b0, busy}, 32'd1);
        if (pulseMid) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        check("busyInWrite", {31'b0, busy}, 32'd1);
        check("strobeInWrite", {31'b0, regWrite}, 32'd1);
        @(negedge clk);
        check("busyInDone", {31'b0, busy}, 32'd0);
        check("doneCycle", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("idleAfterDone", {31'b0, busy}, 32'd0);
        check("holdData", {16'b0, writeData}, {16'b0, e});
    endtask

    initial begin
        #3;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        runOp(8'd13, 8'd11, 16'h008F, 1'b0);
`ifdef MULT_SIGNED_EN
        runOp(8'h80, 8'h80, 16'h4000, 1'b0);
        runOp(8'hFF, 8'h01, 16'hFFFF, 1'b0);
        runOp(8'h80, 8'h7F, 16'hC080, 1'b0);
        runOp(8'hFD, 8'd5,  16'hFFF1, 1'b0);
`else
        runOp(8'd255, 8'd255, 16'hFE01, 1'b0);
        runOp(8'd0,   8'd200, 16'h0000, 1'b0);
        runOp(8'd1,   8'd1,   16'h0001, 1'b0);
`endif

        // Start held through two operations; second accept lands in the done cycle.
        @(negedge clk);
        opA = 8'd7;
        opB = 8'd9;
        start = 1'b1;
        expData.push_back(16'h003F);
        expCyc.push_back(cyc + 1);
        expData.push_back(16'h012C);
        expCyc.push_back(cyc + 11);
        @(negedge clk);
        opA = 8'd100;
        opB = 8'd3;
        repeat (9) @(negedge clk);
        check("heldDone", {31'b0, done}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("heldReaccept", {31'b0, busy}, 32'd1);
        opA = 8'd1;
        opB = 8'd1;
        repeat (11) @(negedge clk);

        // Start pulsed while busy must be ignored.
        runOp(8'd17, 8'd15, 16'h00FF, 1'b1);
        repeat (10) @(negedge clk);
        check("noQueuedStart", {31'b0, busy}, 32'd0);

        // Reset during RUN iteration 4.
        @(negedge clk);
        opA = 8'd200;
        opB = 8'd2;
        start = 1'b1;
        expData.push_back(16'h0190);
        expCyc.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkAllZero("midReset");
        expData.delete();
        expCyc.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (12) @(negedge clk);
        check("dataAfterReset", {16'b0, writeData}, 32'd0);
        check("busyAfterReset", {31'b0, busy}, 32'd0);
        runOp(8'd12, 8'd12, 16'h0090, 1'b0);

        repeat (3) @(negedge clk);
        check("pendingWrites", expData.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/seq_mult_writer.md
# seq_mult_writer

Sequential 8x8 multiplier that feeds the 16-bit product register of the multiplier datapath. Accepts two operands on a start handshake, computes the product by iterative shift-add (or radix-2 Booth when signed mode is compiled in), then drives the product register's `writeData`, `regWrite` and `decOut1b` strobes for exactly one cycle. Sits directly upstream of the 16-bit product register; `writeData` connects straight to the register's data input.

## Interface
- `OPW`, default 8: operand width. The product is 2*OPW bits and must equal 16 to match the product register, so 8 is the only legal value.
- `ITER_W`, default 4: iteration counter width; must satisfy 2^ITER_W > OPW.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `opA`  in  OPW  multiplicand.
- `opB`  in  OPW  multiplier.
- `busy`  out  1  high from the accept edge until the write edge.
- `done`  out  1  one-cycle pulse after the product is written.
- `regWrite`  out  1  product-register write enable.
- `decOut1b`  out  1  product-register select; always equal to `regWrite`.
- `writeData`  out  2*OPW  product to the register.

## Operation
- States: IDLE, RUN, WRITE.
- IDLE with `start=1`:
  - latch `opA` and `opB` into internal registers;
  - clear the accumulator and the iteration counter;
  - go to RUN.
- Operands may change after the accept edge; only the latched copies are used.
- RUN executes one iteration per cycle, OPW iterations in total.
  - Unsigned: if multiplier LSB=1, add the multiplicand to the upper half of the accumulator, keeping the carry-out; then shift {carry, acc} right by 1.
  - Signed (see Configuration): inspect the {LSB, prev} bit pair. 01 adds the multiplicand, 10 subtracts it, 00/11 do nothing. Then arithmetic-shift right by 1.
  - After iteration OPW-1, go to WRITE.
- WRITE:
  - `writeData` = final product;
  - `regWrite` = `decOut1b` = 1;
  - next edge: go to IDLE, `done`=1 for one cycle.
- `writeData` holds the last product until the next WRITE.
- `start` while `busy` is ignored and not queued.
- `start` in the cycle where `done`=1: accepted, because the FSM is already in IDLE.

## Timing
- Reset values (asynchronous): state IDLE; `busy`, `done`, `regWrite`, `decOut1b` = 0; `writeData` = 0; accumulator, operand registers and counter cleared.
- Accept edge E0. RUN occupies the cycles after edges E1..E8; WRITE is the cycle after E8.
- The product register captures at E9. `done` is high during the cycle after E9.
- Start-to-capture latency: 9 cycles. Throughput: one product per 10 cycles when `start` is held high.
- `busy`: 1 from after E0 through E9; 0 in the `done` cycle.
- `regWrite` is high for exactly one cycle per operation and never outside WRITE.
- Reset mid-operation (any state):
  - immediate return to IDLE;
  - no write strobe and no `done`;
  - `writeData` = 0.

## Configuration
- `MULT_SIGNED_EN` defined: operands are two's complement and the core is radix-2 Booth; `writeData` is the signed 16-bit product.
- `MULT_SIGNED_EN` undefined: operands are unsigned and the core is shift-add with carry; `writeData` is the unsigned product.
- Latency and handshake are identical in both builds.

## Test plan
- Unsigned build: `opA`=13, `opB`=11, pulse `start` -> `regWrite`/`decOut1b` high for exactly 1 cycle, 9 cycles after accept, with `writeData`=0x008F; `done` pulses on the next cycle.
- Unsigned build: 255*255 -> 0xFE01; 0*200 -> 0x0000; 1*1 -> 0x0001.
- Signed build: -128*-128 -> 0x4000; -1*1 -> 0xFFFF; -128*127 -> 0xC080.
- Start held high through two operations -> second accept in the `done` cycle; strobes exactly 10 cycles apart; operands changed mid-RUN do not affect the result.
- `start` pulsed during RUN -> ignored; exactly one write occurs.
- `reset` asserted in RUN iteration 4 -> all outputs 0 asynchronously; no `regWrite` or `done` follows; a new start after release produces a correct product.
